// File: rtl/wb_16to8_sequencer.sv
// wb_16to8_sequencer: bridges a 16-bit Wishbone classic master onto an 8-bit
// Wishbone slave bus. Each 16-bit access becomes one or two byte cycles
// (low lane first) under a single held s_cyc_o. Read bytes are assembled
// and a single m_ack_o/m_err_o pulse is returned.
// Optional build macro WB_SEQ_TIMEOUT_EN adds a per-byte watchdog that turns
// a silent slave into an m_err_o after TIMEOUT_CYCLES cycles.
module wb_16to8_sequencer #(
  parameter int AW             = 16,
  parameter int MAX_RETRY      = 3,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic          clk,
  input  logic          rst_n,
  // 16-bit master side
  input  logic [AW-1:0] m_adr_i,
  input  logic [15:0]   m_dat_w_i,
  output logic [15:0]   m_dat_r_o,
  input  logic [1:0]    m_sel_i,
  input  logic          m_we_i,
  input  logic          m_cyc_i,
  input  logic          m_stb_i,
  output logic          m_ack_o,
  output logic          m_err_o,
  // 8-bit slave side
  output logic [AW-1:0] s_adr_o,
  output logic [7:0]    s_dat_w_o,
  input  logic [7:0]    s_dat_r_i,
  output logic          s_we_o,
  output logic          s_cyc_o,
  output logic          s_stb_o,
  input  logic          s_ack_i,
  input  logic          s_err_i,
  input  logic          s_rty_i
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_LO   = 2'd1;
  localparam logic [1:0] ST_HI   = 2'd2;
  localparam logic [1:0] ST_RESP = 2'd3;

  // Extra headroom bit so the counter can hold MAX_RETRY even when it is 0.
  localparam int RW = $clog2(MAX_RETRY + 2);

  logic [1:0]    state_q, state_d;
  logic [AW-2:0] adr_q, adr_d;      // word address, bit 0 supplied per lane
  logic          we_q, we_d;
  logic [1:0]    sel_q, sel_d;
  logic [15:0]   wdat_q, wdat_d;
  logic [15:0]   rbuf_q, rbuf_d;
  logic [RW-1:0] rty_q, rty_d;
  logic          err_q, err_d;

  logic          s_cyc_q, s_cyc_d;
  logic          s_stb_q, s_stb_d;
  logic          s_we_q, s_we_d;
  logic [AW-1:0] s_adr_q, s_adr_d;
  logic [7:0]    s_dat_w_q, s_dat_w_d;
  logic          m_ack_q, m_ack_d;
  logic          m_err_q, m_err_d;
  logic [15:0]   m_dat_r_q, m_dat_r_d;

  logic          to_resp;

`ifdef WB_SEQ_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] to_q, to_d;
  logic          unused_ok;
  assign unused_ok = m_adr_i[0];
`else
  // Address bit 0 is replaced by the lane bit; the watchdog limit has no
  // meaning without the watchdog.
  logic unused_ok;
  assign unused_ok = m_adr_i[0] ^ (TIMEOUT_CYCLES < 0);
`endif

  // Next-state and next-output computation for the byte sequencer.
  always_comb begin
    state_d   = state_q;
    adr_d     = adr_q;
    we_d      = we_q;
    sel_d     = sel_q;
    wdat_d    = wdat_q;
    rbuf_d    = rbuf_q;
    rty_d     = rty_q;
    err_d     = err_q;
    s_cyc_d   = s_cyc_q;
    s_stb_d   = s_stb_q;
    s_we_d    = s_we_q;
    s_adr_d   = s_adr_q;
    s_dat_w_d = s_dat_w_q;
    m_ack_d   = 1'b0;
    m_err_d   = 1'b0;
    m_dat_r_d = m_dat_r_q;
    to_resp   = 1'b0;
`ifdef WB_SEQ_TIMEOUT_EN
    to_d      = to_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (m_cyc_i && m_stb_i) begin
          adr_d  = m_adr_i[AW-1:1];
          we_d   = m_we_i;
          sel_d  = m_sel_i;
          wdat_d = m_dat_w_i;
          rbuf_d = 16'h0000;
          rty_d  = '0;
          err_d  = 1'b0;
`ifdef WB_SEQ_TIMEOUT_EN
          to_d   = '0;
`endif
          if (m_sel_i[0]) begin
            state_d   = ST_LO;
            s_cyc_d   = 1'b1;
            s_stb_d   = 1'b1;
            s_we_d    = m_we_i;
            s_adr_d   = {m_adr_i[AW-1:1], 1'b0};
            s_dat_w_d = m_dat_w_i[7:0];
          end else if (m_sel_i[1]) begin
            state_d   = ST_HI;
            s_cyc_d   = 1'b1;
            s_stb_d   = 1'b1;
            s_we_d    = m_we_i;
            s_adr_d   = {m_adr_i[AW-1:1], 1'b1};
            s_dat_w_d = m_dat_w_i[15:8];
          end else begin
            // No lanes selected: answer without touching the slave bus.
            to_resp = 1'b1;
          end
        end
      end

      ST_LO, ST_HI: begin
        if (!m_cyc_i) begin
          // Master abort: release the slave bus silently.
          state_d = ST_IDLE;
          s_cyc_d = 1'b0;
          s_stb_d = 1'b0;
          s_we_d  = 1'b0;
        end else if (s_err_i) begin
          // err beats a simultaneous ack; remaining byte is skipped.
          err_d   = 1'b1;
          to_resp = 1'b1;
        end else if (s_ack_i) begin
          // ack beats a simultaneous rty.
          rty_d = '0;
          if (!we_q) begin
            if (state_q == ST_LO) begin
              rbuf_d[7:0] = s_dat_r_i;
            end else begin
              rbuf_d[15:8] = s_dat_r_i;
            end
          end
          if ((state_q == ST_LO) && sel_q[1]) begin
            // s_stb stays high; only the lane address/data move.
            state_d   = ST_HI;
            s_adr_d   = {adr_q, 1'b1};
            s_dat_w_d = wdat_q[15:8];
`ifdef WB_SEQ_TIMEOUT_EN
            to_d      = '0;
`endif
          end else begin
            to_resp = 1'b1;
          end
        end else if (s_rty_i) begin
          if (rty_q == RW'(MAX_RETRY)) begin
            err_d   = 1'b1;
            to_resp = 1'b1;
          end else begin
            rty_d = rty_q + RW'(1);
`ifdef WB_SEQ_TIMEOUT_EN
            to_d  = '0;
`endif
          end
        end
`ifdef WB_SEQ_TIMEOUT_EN
        else if (to_q == TW'(TIMEOUT_CYCLES - 1)) begin
          err_d   = 1'b1;
          to_resp = 1'b1;
        end else begin
          to_d = to_q + TW'(1);
        end
`endif
      end

      default: begin
        // ST_RESP: the response pulse is already on the outputs.
        state_d = ST_IDLE;
      end
    endcase

    if (to_resp) begin
      state_d   = ST_RESP;
      s_cyc_d   = 1'b0;
      s_stb_d   = 1'b0;
      s_we_d    = 1'b0;
      m_ack_d   = ~err_d;
      m_err_d   = err_d;
      m_dat_r_d = rbuf_d;
    end
  end

  // State and registered outputs; reset drops the slave cycle immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      adr_q     <= '0;
      we_q      <= 1'b0;
      sel_q     <= 2'b00;
      wdat_q    <= 16'h0000;
      rbuf_q    <= 16'h0000;
      rty_q     <= '0;
      err_q     <= 1'b0;
      s_cyc_q   <= 1'b0;
      s_stb_q   <= 1'b0;
      s_we_q    <= 1'b0;
      s_adr_q   <= '0;
      s_dat_w_q <= 8'h00;
      m_ack_q   <= 1'b0;
      m_err_q   <= 1'b0;
      m_dat_r_q <= 16'h0000;
    end else begin
      state_q   <= state_d;
      adr_q     <= adr_d;
      we_q      <= we_d;
      sel_q     <= sel_d;
      wdat_q    <= wdat_d;
      rbuf_q    <= rbuf_d;
      rty_q     <= rty_d;
      err_q     <= err_d;
      s_cyc_q   <= s_cyc_d;
      s_stb_q   <= s_stb_d;
      s_we_q    <= s_we_d;
      s_adr_q   <= s_adr_d;
      s_dat_w_q <= s_dat_w_d;
      m_ack_q   <= m_ack_d;
      m_err_q   <= m_err_d;
      m_dat_r_q <= m_dat_r_d;
    end
  end

`ifdef WB_SEQ_TIMEOUT_EN
  // Per-byte watchdog counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      to_q <= '0;
    end else begin
      to_q <= to_d;
    end
  end
`endif

  assign s_cyc_o   = s_cyc_q;
  assign s_stb_o   = s_stb_q;
  assign s_we_o    = s_we_q;
  assign s_adr_o   = s_adr_q;
  assign s_dat_w_o = s_dat_w_q;
  assign m_ack_o   = m_ack_q;
  assign m_err_o   = m_err_q;
  assign m_dat_r_o = m_dat_r_q;

endmodule
